sprite_compositor: RTL and testbench
====================================

SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

Interface
REQ-001 SHALL have parameter N_LAYERS, default 26: number of sprite layers, legal range 2..32.
REQ-002 SHALL have parameter RGB_W, default 3: colour bits per pixel.
REQ-003 SHALL have parameter BG_RGB, default 0: colour output when no layer wins.
REQ-004 SHALL have parameter USE_KEY, default 0: 1 enables colour-key transparency.
REQ-005 SHALL have parameter KEY_RGB, default 0: transparent colour when USE_KEY=1.
REQ-006 clk25  in  1  pixel clock; the block has one clock, and all state is on its rising edge.
REQ-007 rst_n  in  1  reset, asynchronous assertion, active-low.
REQ-008 video_on  in  1  current pixel is visible.
REQ-009 frame_end  in  1  single-cycle pulse on the last visible pixel of a frame.
REQ-010 layer_valid  in  N_LAYERS  per-layer sprite-hit flags; bit 0 has the highest priority.
REQ-011 layer_rgb  in  N_LAYERS*RGB_W  per-layer colour; layer i occupies bits [i*RGB_W +: RGB_W].
REQ-012 layer_en  in  N_LAYERS  per-layer enable (alive/active mask).
REQ-013 grp_a  in  N_LAYERS  collision group A membership (e.g. bullets).
REQ-014 grp_b  in  N_LAYERS  collision group B membership (e.g. enemies).
REQ-015 rgb_out  out  RGB_W  composited colour.
REQ-016 video_on_out  out  1  video_on delayed to align with rgb_out.
REQ-017 coll_flags  out  N_LAYERS  per-layer collision result of the last completed frame.
REQ-018 coll_valid  out  1  one-cycle pulse when coll_flags is updated.

Function
REQ-019 Layer i SHALL be eligible when layer_valid[i], layer_en[i] and video_on are all 1, and, if USE_KEY=1, its colour differs from KEY_RGB.
REQ-020 Stage 1 SHALL register the eligible vector, layer_rgb, video_on and frame_end.
REQ-021 Stage 2 SHALL register rgb_out as the colour of the lowest-index eligible layer, or BG_RGB when none is eligible.
REQ-022 Stage 2 SHALL force rgb_out to 0 whenever the stage-1 video_on is 0.
REQ-023 Total latency from input to rgb_out and video_on_out SHALL be exactly 2 cycles.
REQ-024 Using stage-1 data, a layer i SHALL register a hit for a pixel when it is eligible, belongs to group A, and some other eligible layer j (j != i) belongs to group B.
REQ-025 The rule in REQ-024 SHALL apply symmetrically with the group roles swapped, so group B layers also register hits.
REQ-026 A layer that is a member of both groups SHALL never collide with itself.
REQ-027 Per-pixel hits SHALL be OR-accumulated into a frame accumulator of N_LAYERS bits.
REQ-028 When the stage-1 frame_end is 1, coll_flags SHALL load the accumulator OR the current-pixel hits.
REQ-029 In that same cycle, the accumulator SHALL clear to 0 and coll_valid SHALL pulse for 1 cycle.
REQ-030 Pixels after the frame_end pixel SHALL accumulate into the next frame.
REQ-031 coll_flags SHALL hold its value between coll_valid pulses.
REQ-032 frame_end arriving on back-to-back cycles SHALL produce back-to-back pulses, each with its own snapshot.
REQ-033 When the stage-1 video_on is 0, no hits SHALL accumulate.
REQ-034 Changing layer_en mid-frame SHALL affect only subsequent pixels.

Reset
REQ-035 While rst_n is 0, all pipeline registers, the accumulator, rgb_out, video_on_out, coll_flags and coll_valid SHALL be 0.
REQ-036 After rst_n deasserts mid-frame, the first snapshot SHALL contain only hits from after the deassertion.

Structure
REQ-037 The colour width, layer-slice helper constant and default key SHALL reside in shared package sprite_comp_pkg.
REQ-038 Priority selection SHALL be a sub-module layer_prio_enc, which is parametrised by N_LAYERS and returns a found flag and an index.
REQ-039 The collision logic SHALL be contained in sprite_compositor and SHALL use no memories.

Verification (N_LAYERS=4, RGB_W=3)
REQ-040 Stimulus: layer_valid=0110, en=1111, rgb{L1=3'b010, L2=3'b100}, video_on=1. Required response: rgb_out=3'b010 exactly 2 cycles later.
REQ-041 Stimulus: same as REQ-040 with video_on=0. Required response: rgb_out=0 and video_on_out=0; with all layers invalid and video_on=1, rgb_out=BG_RGB.
REQ-042 Stimulus: grp_a=0001, grp_b=0100, layers 0 and 2 valid on one pixel, then frame_end. Required response: coll_flags=0101 with a single coll_valid pulse; the next frame with no overlap gives 0000.
REQ-043 Stimulus: grp_a=grp_b=0001 with layer 0 alone valid. Required response: coll_flags=0000.
REQ-044 Stimulus: USE_KEY=1, KEY_RGB=0, layer 0 valid with rgb=0 and layer 1 valid with rgb=3'b001. Required response: rgb_out=3'b001 and no collision is recorded for layer 0.
REQ-045 Stimulus: an overlap is on the same cycle as frame_end, then rst_n is pulsed mid-frame. Required response: the overlap appears in that frame's snapshot; all outputs go 0 asynchronously on reset; the next snapshot excludes hits from before the reset.

Source files
------------

// File: rtl/sprite_comp_pkg.sv
// Shared constants and helpers for the sprite compositor.
package sprite_comp_pkg;

    // Default colour depth of one layer pixel.
    localparam int unsigned COLOR_W = 3;

    // Colour treated as transparent when colour keying is on.
    localparam logic [COLOR_W-1:0] DEFAULT_KEY = '0;

    // Bit offset of layer `layer` inside a flat per-layer colour bus.
    function automatic int unsigned layer_lsb(input int unsigned layer, input int unsigned width);
        return layer * width;
    endfunction

endpackage

// File: rtl/sprite_compositor_prio_enc.sv
// Fixed-priority encoder: bit 0 of the request vector wins.
module layer_prio_enc #(
    parameter int unsigned N_LAYERS = 26,
    localparam int unsigned IDX_W = $clog2(N_LAYERS)
) (
    input  logic [N_LAYERS-1:0] req,
    output logic                found,
    output logic [IDX_W-1:0]    idx
);

    // Scan from the highest index down so the lowest set bit is written last.
    always_comb begin
        // NOTE: every output gets a value before any branch, so no latch is inferred.
        found = 1'b0;
        idx   = '0;
        for (int i = int'(N_LAYERS) - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/sprite_compositor.sv
// Two-stage sprite layer compositor with per-frame collision snapshots.
module sprite_compositor
    import sprite_comp_pkg::*;
#(
    parameter int unsigned      N_LAYERS = 26,
    parameter int unsigned      RGB_W    = COLOR_W,
    parameter logic [RGB_W-1:0] BG_RGB   = '0,
    parameter int unsigned      USE_KEY  = 0,
    parameter logic [RGB_W-1:0] KEY_RGB  = RGB_W'(DEFAULT_KEY)
) (
    input  logic                      clk25,
    input  logic                      rst_n,
    input  logic                      video_on,
    input  logic                      frame_end,
    input  logic [N_LAYERS-1:0]       layer_valid,
    input  logic [N_LAYERS*RGB_W-1:0] layer_rgb,
    input  logic [N_LAYERS-1:0]       layer_en,
    input  logic [N_LAYERS-1:0]       grp_a,
    input  logic [N_LAYERS-1:0]       grp_b,
    output logic [RGB_W-1:0]          rgb_out,
    output logic                      video_on_out,
    output logic [N_LAYERS-1:0]       coll_flags,
    output logic                      coll_valid
);

    localparam int unsigned IDX_W = $clog2(N_LAYERS);

    // Stage 1 registers (group masks travel with the pixel they belong to).
    logic [N_LAYERS-1:0]       elig_d,  elig_q;
    logic [N_LAYERS*RGB_W-1:0] rgb_s1_d, rgb_s1_q;
    logic                      von_s1_d, von_s1_q;
    logic                      fe_s1_d,  fe_s1_q;
    logic [N_LAYERS-1:0]       ga_s1_d,  ga_s1_q;
    logic [N_LAYERS-1:0]       gb_s1_d,  gb_s1_q;

    // Stage 2 / frame state.
    logic [RGB_W-1:0]          rgb_out_d,    rgb_out_q;
    logic                      von_out_d,    von_out_q;
    logic [N_LAYERS-1:0]       acc_d,        acc_q;
    logic [N_LAYERS-1:0]       coll_flags_d, coll_flags_q;
    logic                      coll_valid_d, coll_valid_q;

    logic                      win_found;
    logic [IDX_W-1:0]          win_idx;
    logic [RGB_W-1:0]          win_rgb;
    logic [N_LAYERS-1:0]       pix_hits;

    // Per-layer eligibility and stage-1 capture values.
    always_comb begin
        elig_d = '0;
        for (int i = 0; i < int'(N_LAYERS); i++) begin
            elig_d[i] = layer_valid[i] & layer_en[i] & video_on &
                        ((USE_KEY == 0) ||
                         (layer_rgb[layer_lsb(i, RGB_W) +: RGB_W] != KEY_RGB));
        end
        rgb_s1_d = layer_rgb;
        von_s1_d = video_on;
        fe_s1_d  = frame_end;
        ga_s1_d  = grp_a;
        gb_s1_d  = grp_b;
    end

    // Stage 1 pipeline register.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            elig_q   <= '0;
            rgb_s1_q <= '0;
            von_s1_q <= 1'b0;
            fe_s1_q  <= 1'b0;
            ga_s1_q  <= '0;
            gb_s1_q  <= '0;
        end else begin
            // NOTE: non-blocking updates keep every flop sampling pre-edge values.
            elig_q   <= elig_d;
            rgb_s1_q <= rgb_s1_d;
            von_s1_q <= von_s1_d;
            fe_s1_q  <= fe_s1_d;
            ga_s1_q  <= ga_s1_d;
            gb_s1_q  <= gb_s1_d;
        end
    end

    layer_prio_enc #(.N_LAYERS(N_LAYERS)) u_prio (
        .req   (elig_q),
        .found (win_found),
        .idx   (win_idx)
    );

    // Pick the winning layer's colour; blank outside the visible area.
    always_comb begin
        win_rgb = '0;
        for (int i = 0; i < int'(N_LAYERS); i++) begin
            if (win_idx == IDX_W'(i)) begin
                win_rgb = rgb_s1_q[layer_lsb(i, RGB_W) +: RGB_W];
            end
        end
        if (!von_s1_q) begin
            rgb_out_d = '0;
        end else if (win_found) begin
            rgb_out_d = win_rgb;
        end else begin
            rgb_out_d = BG_RGB;
        end
        von_out_d = von_s1_q;
    end

    // A-vs-B overlap per layer, excluding a layer's own membership in both groups.
    always_comb begin
        logic [N_LAYERS-1:0] elig_a;
        logic [N_LAYERS-1:0] elig_b;
        logic [N_LAYERS-1:0] other_mask;
        elig_a     = elig_q & ga_s1_q;
        elig_b     = elig_q & gb_s1_q;
        other_mask = '0;
        pix_hits   = '0;
        for (int i = 0; i < int'(N_LAYERS); i++) begin
            other_mask  = ~(N_LAYERS'(1) << i);
            pix_hits[i] = (elig_a[i] & (|(elig_b & other_mask))) |
                          (elig_b[i] & (|(elig_a & other_mask)));
        end
    end

    // Frame accumulator and snapshot on the stage-1 frame_end pixel.
    always_comb begin
        if (fe_s1_q) begin
            acc_d        = '0;
            coll_flags_d = acc_q | pix_hits;
            coll_valid_d = 1'b1;
        end else begin
            acc_d        = acc_q | pix_hits;
            coll_flags_d = coll_flags_q;
            coll_valid_d = 1'b0;
        end
    end

    // Stage 2 output and collision registers.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the accumulator is plain flops, so reset clears it and no pre-reset hit survives.
            rgb_out_q    <= '0;
            von_out_q    <= 1'b0;
            acc_q        <= '0;
            coll_flags_q <= '0;
            coll_valid_q <= 1'b0;
        end else begin
            rgb_out_q    <= rgb_out_d;
            von_out_q    <= von_out_d;
            acc_q        <= acc_d;
            coll_flags_q <= coll_flags_d;
            coll_valid_q <= coll_valid_d;
        end
    end

    assign rgb_out      = rgb_out_q;
    assign video_on_out = von_out_q;
    assign coll_flags   = coll_flags_q;
    assign coll_valid   = coll_valid_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Self-checking bench: two compositor instances (plain and colour-keyed) against a behavioural model.
module tb_sprite_compositor;

    localparam int N = 4;
    localparam int W = 3;
    localparam logic [2:0] BG0 = 3'b101;
    localparam logic [2:0] BG1 = 3'b011;

    logic        clk25 = 1'b0;
    logic        rst_n = 1'b0;
    logic        video_on, frame_end;
    logic [3:0]  layer_valid, layer_en, grp_a, grp_b;
    logic [11:0] layer_rgb;

    logic [2:0]  rgb0, rgb1;
    logic        von0, von1, cv0, cv1;
    logic [3:0]  flags0, flags1;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk25 = ~clk25;

    sprite_compositor #(.N_LAYERS(N), .RGB_W(W), .BG_RGB(BG0), .USE_KEY(0), .KEY_RGB(3'b000)) u_dut0 (
        .clk25(clk25), .rst_n(rst_n), .video_on(video_on), .frame_end(frame_end),
        .layer_valid(layer_valid), .layer_rgb(layer_rgb), .layer_en(layer_en),
        .grp_a(grp_a), .grp_b(grp_b), .rgb_out(rgb0), .video_on_out(von0),
        .coll_flags(flags0), .coll_valid(cv0)
    );

    sprite_compositor #(.N_LAYERS(N), .RGB_W(W), .BG_RGB(BG1), .USE_KEY(1), .KEY_RGB(3'b000)) u_dut1 (
        .clk25(clk25), .rst_n(rst_n), .video_on(video_on), .frame_end(frame_end),
        .layer_valid(layer_valid), .layer_rgb(layer_rgb), .layer_en(layer_en),
        .grp_a(grp_a), .grp_b(grp_b), .rgb_out(rgb1), .video_on_out(von1),
        .coll_flags(flags1), .coll_valid(cv1)
    );

    // ---------------- behavioural model ----------------
    logic [3:0]  m_elig [2];
    logic [11:0] m_rgb;
    logic        m_von, m_fe;
    logic [3:0]  m_ga, m_gb;
    logic [3:0]  m_acc  [2];
    logic [2:0]  e_rgb  [2];
    logic        e_von  [2];
    logic [3:0]  e_flags[2];
    logic        e_cv   [2];

    function automatic logic [3:0] eligible(input int inst);
        logic [3:0] e;
        logic [2:0] c;
        e = '0;
        for (int i = 0; i < N; i++) begin
            c = layer_rgb[i*W +: W];
            e[i] = layer_valid[i] && layer_en[i] && video_on && !(inst == 1 && c == 3'b000);
        end
        return e;
    endfunction

    function automatic logic [2:0] composite(input logic [3:0] e, input logic [11:0] rgb,
                                             input logic von, input logic [2:0] bg);
        if (!von) return 3'b000;
        for (int i = 0; i < N; i++) if (e[i]) return rgb[i*W +: W];
        return bg;
    endfunction

    function automatic logic [3:0] pixel_hits(input logic [3:0] e, input logic [3:0] ga, input logic [3:0] gb);
        logic [3:0] h;
        h = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (i != j && e[i] && e[j] && ((ga[i] && gb[j]) || (gb[i] && ga[j])))
                    h[i] = 1'b1;
        return h;
    endfunction

    task automatic model_reset();
        m_rgb = '0; m_von = 0; m_fe = 0; m_ga = '0; m_gb = '0;
        for (int k = 0; k < 2; k++) begin
            m_elig[k] = '0; m_acc[k] = '0;
            e_rgb[k] = '0; e_von[k] = 0; e_flags[k] = '0; e_cv[k] = 0;
        end
    endtask

    task automatic model_step();
        logic [3:0] h;
        for (int k = 0; k < 2; k++) begin
            e_rgb[k] = composite(m_elig[k], m_rgb, m_von, (k == 0) ? BG0 : BG1);
            e_von[k] = m_von;
            h = pixel_hits(m_elig[k], m_ga, m_gb);
            if (m_fe) begin
                e_flags[k] = m_acc[k] | h;
                e_cv[k]    = 1'b1;
                m_acc[k]   = '0;
            end else begin
                m_acc[k] = m_acc[k] | h;
                e_cv[k]  = 1'b0;
            end
        end
        m_elig[0] = eligible(0);
        m_elig[1] = eligible(1);
        m_rgb = layer_rgb; m_von = video_on; m_fe = frame_end;
        m_ga = grp_a; m_gb = grp_b;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every cycle, both instances against the model.
    always @(negedge clk25) begin
        check("rgb0",   32'(rgb0),   32'(e_rgb[0]));
        check("von0",   32'(von0),   32'(e_von[0]));
        check("flags0", 32'(flags0), 32'(e_flags[0]));
        check("cv0",    32'(cv0),    32'(e_cv[0]));
        check("rgb1",   32'(rgb1),   32'(e_rgb[1]));
        check("von1",   32'(von1),   32'(e_von[1]));
        check("flags1", 32'(flags1), 32'(e_flags[1]));
        check("cv1",    32'(cv1),    32'(e_cv[1]));
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [3:0] v, input logic [11:0] rgb, input logic [3:0] en,
                         input logic [3:0] ga, input logic [3:0] gb, input logic von, input logic fe);
        layer_valid = v; layer_rgb = rgb; layer_en = en;
        grp_a = ga; grp_b = gb; video_on = von; frame_end = fe;
    endtask

    task automatic idle();
        drive(4'b0000, 12'h000, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic cycle();
        @(posedge clk25);
        if (rst_n) model_step();
        @(negedge clk25);
    endtask

    localparam logic [11:0] RGB_T = 12'b011_100_010_111;  // L3 L2 L1 L0
    localparam logic [11:0] RGB_K = 12'b011_100_001_000;

    initial begin
        model_reset();
        idle();
        #1;
        check("lit_rst_rgb",   32'(rgb0),   32'h0);
        check("lit_rst_flags", 32'(flags0), 32'h0);
        check("lit_rst_cv",    32'(cv0),    32'h0);
        repeat (3) cycle();
        #1 rst_n = 1'b1;

        // Priority and latency
        drive(4'b0110, RGB_T, 4'hF, 4'h0, 4'h0, 1'b1, 1'b0); cycle();
        check("lit_lat1", 32'(rgb0), 32'h0);
        drive(4'b0110, RGB_T, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0); cycle();
        check("lit_prio_rgb", 32'(rgb0), 32'h2);
        check("lit_prio_von", 32'(von0), 32'h1);
        drive(4'b0000, RGB_T, 4'hF, 4'h0, 4'h0, 1'b1, 1'b0); cycle();
        check("lit_voff_rgb", 32'(rgb0), 32'h0);
        check("lit_voff_von", 32'(von0), 32'h0);
        idle(); cycle();
        check("lit_bg0", 32'(rgb0), 32'(BG0));
        check("lit_bg1", 32'(rgb1), 32'(BG1));

        // Basic collision then a clean frame
        drive(4'b0101, RGB_T, 4'hF, 4'b0001, 4'b0100, 1'b1, 1'b0); cycle();
        drive(4'b0000, RGB_T, 4'hF, 4'b0001, 4'b0100, 1'b1, 1'b1); cycle();
        idle(); cycle();
        check("lit_coll_valid", 32'(cv0),    32'h1);
        check("lit_coll_flags", 32'(flags0), 32'h5);
        drive(4'b0001, RGB_T, 4'hF, 4'b0001, 4'b0100, 1'b1, 1'b1); cycle();
        check("lit_coll_pulse", 32'(cv0),    32'h0);
        check("lit_coll_hold",  32'(flags0), 32'h5);
        idle(); cycle();
        check("lit_clean_valid", 32'(cv0),    32'h1);
        check("lit_clean_flags", 32'(flags0), 32'h0);

        // Self-membership never collides; two dual members collide with each other
        drive(4'b0001, RGB_T, 4'hF, 4'b0001, 4'b0001, 1'b1, 1'b1); cycle();
        idle(); cycle();
        check("lit_self_flags", 32'(flags0), 32'h0);
        drive(4'b0011, RGB_T, 4'hF, 4'b0011, 4'b0011, 1'b1, 1'b1); cycle();
        idle(); cycle();
        check("lit_dual_flags", 32'(flags0), 32'h3);

        // Colour key
        drive(4'b0011, RGB_K, 4'hF, 4'b0001, 4'b0010, 1'b1, 1'b1); cycle();
        idle(); cycle();
        check("lit_key_rgb1",   32'(rgb1),   32'h1);
        check("lit_key_flags1", 32'(flags1), 32'h0);
        check("lit_key_cv1",    32'(cv1),    32'h1);
        check("lit_nokey_rgb0", 32'(rgb0),   32'h0);
        check("lit_nokey_flg0", 32'(flags0), 32'h3);

        // Back-to-back frame_end
        drive(4'b0101, RGB_T, 4'hF, 4'b0001, 4'b0100, 1'b1, 1'b1); cycle();
        drive(4'b0000, RGB_T, 4'hF, 4'b0001, 4'b0100, 1'b1, 1'b1); cycle();
        check("lit_b2b_cv_a",  32'(cv0),    32'h1);
        check("lit_b2b_flg_a", 32'(flags0), 32'h5);
        idle(); cycle();
        check("lit_b2b_cv_b",  32'(cv0),    32'h1);
        check("lit_b2b_flg_b", 32'(flags0), 32'h0);

        // Overlap on frame_end, then a mid-frame reset
        drive(4'b0101, RGB_T, 4'hF, 4'b0001, 4'b0100, 1'b1, 1'b1); cycle();
        drive(4'b0101, RGB_T, 4'hF, 4'b0001, 4'b0100, 1'b1, 1'b0); cycle();
        check("lit_fe_ovl_cv",  32'(cv0),    32'h1);
        check("lit_fe_ovl_flg", 32'(flags0), 32'h5);
        idle(); cycle();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("lit_arst_rgb", 32'(rgb0),   32'h0);
        check("lit_arst_von", 32'(von0),   32'h0);
        check("lit_arst_flg", 32'(flags0), 32'h0);
        check("lit_arst_cv",  32'(cv0),    32'h0);
        cycle(); cycle();
        #1 rst_n = 1'b1;
        drive(4'b0000, RGB_T, 4'hF, 4'b0001, 4'b0100, 1'b1, 1'b1); cycle();
        idle(); cycle();
        check("lit_post_rst_cv",  32'(cv0),    32'h1);
        check("lit_post_rst_flg", 32'(flags0), 32'h0);

        // Randomised traffic, with one asynchronous reset in the middle
        for (int k = 0; k < 3000; k++) begin
            drive(4'($urandom), 12'($urandom),
                  ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF,
                  4'($urandom), 4'($urandom),
                  ($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 15) == 0));
            cycle();
            if (k == 1500) begin
                #2 rst_n = 1'b0;
                model_reset();
                cycle();
                #1 rst_n = 1'b1;
            end
        end

        idle(); cycle(); cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
